traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
- Passive checker on the red/amber/green lamp bus of the traffic-light sequencer.
- Samples the three lamp lines every clock and tracks the UK phase.
- Flags illegal lamp patterns, out-of-order transitions and over-long dwell.
- Counts completed light cycles; used in the bench and as an on-chip safety monitor.

Parameters:
- MAX_DWELL, 16: maximum number of consecutive samples any single pattern may persist before a timeout is flagged (must be ≥ 1).
- CNT_W, 8: width of the completed-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- red  input  1  red lamp line.
- amber  input  1  amber lamp line.
- green  input  1  green lamp line.
- clear  input  1  synchronous clear of err_sticky.
- locked  output  1  monitor is tracking a legal phase.
- phase  output  2  current phase: 00 RED, 01 RED_AMBER, 10 GREEN, 11 AMBER; meaningful only when locked = 1.
- seq_err  output  1  one-cycle pulse on an illegal transition between legal patterns.
- bad_pattern  output  1  one-cycle pulse on an illegal lamp code.
- timeout  output  1  one-cycle pulse when dwell exceeds MAX_DWELL.
- err_sticky  output  1  set by any error; cleared by clear.
- cycles  output  CNT_W  count of completed cycles; wraps modulo 2^CNT_W.

Behaviour:
- Clock, reset and I/O
  - Single clock domain is clk; reset is asynchronous, active-low (rst_n).
  - All outputs are registered.
  - Lamp code p = {red, amber, green} is sampled at each rising edge; results are visible after that same edge (1-cycle latency).
- Reset (rst_n low, immediate, independent of clk):
  - locked = 0, phase = 00, seq_err = 0, bad_pattern = 0, timeout = 0, err_sticky = 0, cycles = 0.
  - Internal prev-pattern register = 000; dwell counter = 0.
- Legal codes and successor order:
  - 100 → RED, 110 → RED_AMBER, 001 → GREEN, 010 → AMBER.
  - Successor order is RED → RED_AMBER → GREEN → AMBER → RED.
- Per-edge decision (first matching rule applies; pulse outputs default to 0 every edge):
  1. p illegal (000, 011, 101, 111): bad_pattern = 1, err_sticky = 1, locked = 0, dwell = 0; phase holds its last value.
  2. p legal and locked = 0: locked = 1, phase = enc(p), dwell = 1. No error is raised; the first legal code is always accepted.
  3. p equals prev (locked):
     - If dwell = MAX_DWELL: timeout = 1, err_sticky = 1, dwell saturates at MAX_DWELL + 1.
     - If dwell > MAX_DWELL: no further pulse.
     - Otherwise: dwell increments.
  4. p = successor(phase): phase = enc(p), dwell = 1. If the old phase is AMBER and the new phase is RED, cycles increments (wrapping).
  5. Otherwise (legal but out of order): seq_err = 1, err_sticky = 1, phase = enc(p) (resynchronise), dwell = 1, locked stays 1, cycles unchanged.
- prev is updated to p on every edge.
- err_sticky priority: if clear = 1 on the same edge an error is raised, err_sticky = 1 (error wins). With clear = 1 and no error, err_sticky = 0.
- clear has no effect on locked, phase, cycles or dwell.
- Dwell register width is clog2(MAX_DWELL + 2).
- Driven by the sequencer (one cycle per phase), dwell is always 1; a clean run never times out.

Test Plan:
1. Reset, then drive 100, 110, 001, 010, 100 one per cycle → locked = 1 after the first edge; phase = 0, 1, 2, 3, 0; cycles = 1 after the last edge; no error pulses; err_sticky = 0.
2. Locked in RED (100), then drive 001 → seq_err high for exactly one cycle, err_sticky = 1, phase = 10, locked = 1, cycles unchanged.
3. Drive 111 while locked → bad_pattern pulses once, locked = 0. Next drive 110 → locked = 1, phase = 01, no seq_err.
4. MAX_DWELL = 4: hold 100 for 7 edges → timeout pulses only on the 5th edge; then 110 → dwell resets, no further timeout.
5. With err_sticky = 1, assert clear on the same edge as a seq_err → err_sticky stays 1. Assert clear alone on the next edge → err_sticky = 0.
6. CNT_W = 2: run 4 full legal loops → cycles goes 1, 2, 3, 0. Then pulse rst_n low between edges mid-loop → all outputs read 0 before the next clk edge.

Source files
------------

// File: rtl/traffic_light_monitor_if.sv
// Lamp bus between the traffic-light sequencer and its passive monitor.
// The sequencer side (master) drives lamps and clear; the monitor (slave) reports status.
interface traffic_light_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             red;
    logic             amber;
    logic             green;
    logic             clear;
    logic             locked;
    logic [1:0]       phase;
    logic             seq_err;
    logic             bad_pattern;
    logic             timeout;
    logic             err_sticky;
    logic [CNT_W-1:0] cycles;

    modport master (
        output red, amber, green, clear,
        input  locked, phase, seq_err, bad_pattern, timeout, err_sticky, cycles
    );

    modport slave (
        input  red, amber, green, clear,
        output locked, phase, seq_err, bad_pattern, timeout, err_sticky, cycles
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for the UK red/amber/green lamp sequence: flags illegal codes,
// out-of-order transitions and over-long dwell, and counts completed light cycles.
module traffic_light_monitor #(
    parameter int unsigned MAX_DWELL = 16,
    parameter int unsigned CNT_W     = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    traffic_light_monitor_if.slave  lamp_bus
);
    localparam int unsigned DwW = $clog2(MAX_DWELL + 2);

    localparam logic [1:0] PhRed      = 2'd0;
    localparam logic [1:0] PhRedAmber = 2'd1;
    localparam logic [1:0] PhGreen    = 2'd2;
    localparam logic [1:0] PhAmber    = 2'd3;

    logic [2:0]       w_p;
    logic             w_legal;
    logic [1:0]       w_enc;
    logic             w_err;

    logic             r_locked,     w_locked_d;
    logic [1:0]       r_phase,      w_phase_d;
    logic             r_seq_err,    w_seq_err_d;
    logic             r_bad,        w_bad_d;
    logic             r_timeout,    w_timeout_d;
    logic             r_sticky,     w_sticky_d;
    logic [CNT_W-1:0] r_cycles,     w_cycles_d;
    logic [2:0]       r_prev;
    logic [DwW-1:0]   r_dwell,      w_dwell_d;

    assign w_p = {lamp_bus.red, lamp_bus.amber, lamp_bus.green};

    always_comb begin
        w_legal = 1'b1;
        w_enc   = PhRed;
        unique case (w_p)
            3'b100:  w_enc = PhRed;
            3'b110:  w_enc = PhRedAmber;
            3'b001:  w_enc = PhGreen;
            3'b010:  w_enc = PhAmber;
            default: w_legal = 1'b0;
        endcase
    end

    // First matching rule wins; pulses default low every edge.
    always_comb begin
        w_locked_d  = r_locked;
        w_phase_d   = r_phase;
        w_cycles_d  = r_cycles;
        w_dwell_d   = r_dwell;
        w_seq_err_d = 1'b0;
        w_bad_d     = 1'b0;
        w_timeout_d = 1'b0;
        w_err       = 1'b0;

        if (!w_legal) begin
            w_bad_d    = 1'b1;
            w_err      = 1'b1;
            w_locked_d = 1'b0;
            w_dwell_d  = '0;
        end else if (!r_locked) begin
            w_locked_d = 1'b1;
            w_phase_d  = w_enc;
            w_dwell_d  = DwW'(1);
        end else if (w_p == r_prev) begin
            if (r_dwell == DwW'(MAX_DWELL)) begin
                w_timeout_d = 1'b1;
                w_err       = 1'b1;
                w_dwell_d   = DwW'(MAX_DWELL + 1);
            end else if (r_dwell < DwW'(MAX_DWELL)) begin
                w_dwell_d = r_dwell + DwW'(1);
            end
        end else if (w_enc == r_phase + 2'd1) begin
            w_phase_d = w_enc;
            w_dwell_d = DwW'(1);
            if (r_phase == PhAmber) begin
                w_cycles_d = r_cycles + CNT_W'(1);
            end
        end else begin
            w_seq_err_d = 1'b1;
            w_err       = 1'b1;
            w_phase_d   = w_enc;
            w_dwell_d   = DwW'(1);
        end

        // A new error outranks a simultaneous clear.
        if (w_err) begin
            w_sticky_d = 1'b1;
        end else if (lamp_bus.clear) begin
            w_sticky_d = 1'b0;
        end else begin
            w_sticky_d = r_sticky;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked  <= 1'b0;
            r_phase   <= PhRed;
            r_seq_err <= 1'b0;
            r_bad     <= 1'b0;
            r_timeout <= 1'b0;
            r_sticky  <= 1'b0;
            r_cycles  <= '0;
            r_prev    <= 3'b000;
            r_dwell   <= '0;
        end else begin
            r_locked  <= w_locked_d;
            r_phase   <= w_phase_d;
            r_seq_err <= w_seq_err_d;
            r_bad     <= w_bad_d;
            r_timeout <= w_timeout_d;
            r_sticky  <= w_sticky_d;
            r_cycles  <= w_cycles_d;
            r_prev    <= w_p;
            r_dwell   <= w_dwell_d;
        end
    end

    assign lamp_bus.locked      = r_locked;
    assign lamp_bus.phase       = r_phase;
    assign lamp_bus.seq_err     = r_seq_err;
    assign lamp_bus.bad_pattern = r_bad;
    assign lamp_bus.timeout     = r_timeout;
    assign lamp_bus.err_sticky  = r_sticky;
    assign lamp_bus.cycles      = r_cycles;
endmodule
